tcdm_bank_arbiter: RTL and testbench
====================================

TCDM_BANK_ARBITER -- requirements
Module: tcdm_bank_arbiter

Interface
REQ-001: Parameter NumInp, default 2, number of requester ports (2..8).
REQ-002: Parameter DataWidth, default 64, SRAM word width in bits.
REQ-003: Parameter MemAddrWidth, default 9, bank word-address width.
REQ-004: Parameter IdxWidth, default $clog2(NumInp), port-index width.
REQ-005: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006: rst_ni  in  1  reset, asynchronous, active-low.
REQ-007: req_valid_i  in  NumInp  per-port request valid.
REQ-008: req_write_i  in  NumInp  per-port 1=write, 0=read.
REQ-009: req_addr_i  in  NumInp x MemAddrWidth  per-port word address.
REQ-010: req_data_i  in  NumInp x DataWidth  per-port write data.
REQ-011: req_strb_i  in  NumInp x DataWidth/8  per-port byte enables.
REQ-012: req_ready_o  out  NumInp  per-port request accepted this cycle.
REQ-013: rsp_valid_o  out  NumInp  per-port read-data valid.
REQ-014: rsp_data_o  out  NumInp x DataWidth  per-port read data.
REQ-015: mem_req_o  out  1  SRAM chip select.
REQ-016: mem_gnt_i  in  1  bank able to accept an access this cycle.
REQ-017: mem_we_o  out  1  SRAM write enable.
REQ-018: mem_addr_o  out  MemAddrWidth  SRAM address.
REQ-019: mem_wdata_o  out  DataWidth  SRAM write data.
REQ-020: mem_be_o  out  DataWidth/8  SRAM byte enables.
REQ-021: mem_rdata_i  in  DataWidth  SRAM read data, valid one cycle after accepted access.

Function
REQ-022: Round-robin pointer ptr (IdxWidth bits) SHALL select the winner: first valid port at index ptr, ptr+1, ... wrapping modulo NumInp.
REQ-023: mem_req_o SHALL equal OR of req_valid_i; mem_we_o/addr/wdata/be SHALL carry the winner's fields combinationally; with no valid request they SHALL be 0.
REQ-024: req_ready_o[i] SHALL be 1 only for the winner and only when mem_gnt_i=1; at most one bit set per cycle.
REQ-025: Acceptance = mem_req_o & mem_gnt_i; on acceptance ptr SHALL become (winner+1) mod NumInp; otherwise ptr holds.
REQ-026: With mem_gnt_i=0, no port is ready, ptr holds, and the winner is recomputed next cycle (a new higher-priority request may overtake).
REQ-027: Accepted read SHALL register winner index and a read flag; next cycle rsp_valid_o[idx]=1 and rsp_data_o[idx]=mem_rdata_i; all other ports rsp_valid_o=0, rsp_data_o=0.
REQ-028: Accepted write SHALL produce no response; rsp_valid_o all 0 in the following cycle.
REQ-029: Back-to-back accepted reads SHALL give one response per cycle, fixed latency 1, no response-side backpressure.
REQ-030: Requester SHALL hold valid and fields stable until ready; arbiter SHALL NOT depend on this for correctness of ptr.
REQ-031: Single valid port SHALL be granted every cycle mem_gnt_i=1 regardless of ptr.

Reset
REQ-032: While rst_ni=0: ptr=0, registered read flag=0, rsp_valid_o=0, rsp_data_o=0; combinational outputs follow REQ-023/024.
REQ-033: Reset asserted mid-operation SHALL discard any pending response; no rsp_valid_o in the cycle after reset release.

Verification
REQ-034: NumInp=2, both ports read every cycle, mem_gnt_i=1 -> grants alternate 0,1,0,1; each rsp_valid_o one cycle after its ready.
REQ-035: Port1 write addr 5 data 0xAAAA strb 0xFF, then port0 read addr 5 -> rsp_valid_o[0]=1 with rsp_data_o[0]=0xAAAA; no response for the write.
REQ-036: Both valid, mem_gnt_i=0 for 3 cycles -> req_ready_o=0, ptr unchanged, mem_req_o=1; on gnt=1 port at ptr wins first.
REQ-037: NumInp=4, ports 1 and 3 valid, ptr=2 -> port 3 granted, ptr becomes 0, then port 1 granted.
REQ-038: Read accepted, rst_ni low next cycle -> rsp_valid_o=0 during and after reset, ptr=0.
REQ-039: Only port 0 valid for 10 cycles, gnt=1 -> 10 consecutive grants, 10 responses, no idle cycles.

Source files
------------

// File: rtl/tcdm_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tcdm_bank_arbiter
//
// Round-robin arbiter that lets NumInp requesters share one single-ported
// SRAM bank. Each cycle the first valid port found when scanning from the
// round-robin pointer (wrapping) is the winner. Its fields are routed
// combinationally to the bank. The access is accepted when the bank grants
// it. Read data comes back one cycle after acceptance and is steered to the
// port that issued the read. Writes produce no response.
//
// Parameters
//   NumInp       number of requester ports (2..8)
//   DataWidth    SRAM word width in bits
//   MemAddrWidth bank word-address width
//   IdxWidth     port-index width
//
// Ports
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_valid_i    per-port request valid
//   req_write_i    per-port 1=write, 0=read
//   req_addr_i     per-port word address
//   req_data_i     per-port write data
//   req_strb_i     per-port byte enables
//   req_ready_o    per-port "request accepted this cycle" (at most one set)
//   rsp_valid_o    per-port read-data valid
//   rsp_data_o     per-port read data (zero on ports without a response)
//   mem_req_o      SRAM chip select (any request valid)
//   mem_gnt_i      bank can accept an access this cycle
//   mem_we_o       SRAM write enable
//   mem_addr_o     SRAM address
//   mem_wdata_o    SRAM write data
//   mem_be_o       SRAM byte enables
//   mem_rdata_i    SRAM read data, valid one cycle after an accepted access
// ---------------------------------------------------------------------------
module tcdm_bank_arbiter #(
  parameter int unsigned NumInp       = 2,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned MemAddrWidth = 9,
  parameter int unsigned IdxWidth     = $clog2(NumInp)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumInp-1:0]                      req_valid_i,
  input  logic [NumInp-1:0]                      req_write_i,
  input  logic [NumInp-1:0][MemAddrWidth-1:0]    req_addr_i,
  input  logic [NumInp-1:0][DataWidth-1:0]       req_data_i,
  input  logic [NumInp-1:0][DataWidth/8-1:0]     req_strb_i,
  output logic [NumInp-1:0]                      req_ready_o,
  output logic [NumInp-1:0]                      rsp_valid_o,
  output logic [NumInp-1:0][DataWidth-1:0]       rsp_data_o,
  output logic                                   mem_req_o,
  input  logic                                   mem_gnt_i,
  output logic                                   mem_we_o,
  output logic [MemAddrWidth-1:0]                mem_addr_o,
  output logic [DataWidth-1:0]                   mem_wdata_o,
  output logic [DataWidth/8-1:0]                 mem_be_o,
  input  logic [DataWidth-1:0]                   mem_rdata_i
);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumInp - 1);

  // Round-robin pointer: the port with the highest priority this cycle.
  logic [IdxWidth-1:0] ptr_q;

  // Read-response tracking: a read was accepted last cycle, and by whom.
  logic                rsp_pending_q;
  logic [IdxWidth-1:0] rsp_idx_q;

  logic                win_found;
  logic [IdxWidth-1:0] win_idx;
  logic                accept;
  logic [IdxWidth-1:0] ptr_next;

  // -------------------------------------------------------------------------
  // Winner search: scan ptr, ptr+1, ... wrapping modulo NumInp. The pointer
  // never exceeds NumInp-1, so one conditional subtraction implements the
  // wrap even when NumInp is not a power of two.
  // -------------------------------------------------------------------------
  always_comb begin
    int unsigned         cand;
    logic [IdxWidth-1:0] cand_idx;
    // NOTE: every variable assigned in always_comb gets a default before any
    // conditional assignment; otherwise a path that skips it infers a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NumInp; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NumInp) begin
        cand = cand - NumInp;
      end
      cand_idx = cand[IdxWidth-1:0];
      if (!win_found && req_valid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Bank-side request: the winner's fields, or all zero when nobody asks.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_req_o   = |req_valid_i;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (win_found) begin
      mem_we_o    = req_write_i[win_idx];
      mem_addr_o  = req_addr_i[win_idx];
      mem_wdata_o = req_data_i[win_idx];
      mem_be_o    = req_strb_i[win_idx];
    end
  end

  // Ready is one-hot on the winner, and only when the bank grants. Without a
  // grant nothing is consumed, so a higher-priority request arriving next
  // cycle may still overtake the current winner.
  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      req_ready_o[i] = win_found && mem_gnt_i && (win_idx == IdxWidth'(i));
    end
  end

  assign accept   = mem_req_o & mem_gnt_i;
  assign ptr_next = (win_idx == LastIdx) ? '0 : win_idx + IdxWidth'(1);

  // -------------------------------------------------------------------------
  // State: pointer moves past the winner on every accepted access, and an
  // accepted read arms a one-cycle response for the winning port.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge, independent of order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q         <= '0;
      rsp_pending_q <= 1'b0;
      rsp_idx_q     <= '0;
    end else begin
      if (accept) begin
        ptr_q     <= ptr_next;
        rsp_idx_q <= win_idx;
      end
      rsp_pending_q <= accept & ~mem_we_o;
    end
  end

  // -------------------------------------------------------------------------
  // Response steering: SRAM read data goes to exactly the port that issued
  // the read; every other port sees zero. Because the pending flag is cleared
  // by reset, a read accepted just before reset never produces a response.
  // -------------------------------------------------------------------------
  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    if (rsp_pending_q) begin
      rsp_valid_o[rsp_idx_q] = 1'b1;
      rsp_data_o[rsp_idx_q]  = mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tcdm_bank_arbiter
//
// Two arbiter instances (NumInp=4 and NumInp=2) each drive a small SRAM
// model whose unwritten words read as 0x1000 + address. Stimulus issues
// directed requests, checks the combinational bank-side outputs directly,
// and pushes each expected read response (port, data, due cycle) into a
// per-instance queue. A monitor on the falling edge pops and compares
// whenever an instance presents a response.
// ---------------------------------------------------------------------------
module tb_tcdm_bank_arbiter;

  typedef struct {
    int          port;
    logic [63:0] data;
    int          due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb4[$];
  exp_t sb2[$];

  // ---------------- NumInp = 4 instance ----------------
  logic [3:0]            v4, w4, ready4, rspv4;
  logic [3:0][8:0]       a4;
  logic [3:0][63:0]      d4, rspd4;
  logic [3:0][7:0]       s4;
  logic                  mreq4, gnt4, mwe4;
  logic [8:0]            maddr4;
  logic [63:0]           mwdata4, mrdata4;
  logic [7:0]            mbe4;

  tcdm_bank_arbiter #(.NumInp(4), .DataWidth(64), .MemAddrWidth(9)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v4), .req_write_i(w4), .req_addr_i(a4), .req_data_i(d4),
    .req_strb_i(s4), .req_ready_o(ready4), .rsp_valid_o(rspv4),
    .rsp_data_o(rspd4), .mem_req_o(mreq4), .mem_gnt_i(gnt4), .mem_we_o(mwe4),
    .mem_addr_o(maddr4), .mem_wdata_o(mwdata4), .mem_be_o(mbe4),
    .mem_rdata_i(mrdata4)
  );

  // ---------------- NumInp = 2 instance ----------------
  logic [1:0]            v2, w2, ready2, rspv2;
  logic [1:0][8:0]       a2;
  logic [1:0][63:0]      d2, rspd2;
  logic [1:0][7:0]       s2;
  logic                  mreq2, gnt2, mwe2;
  logic [8:0]            maddr2;
  logic [63:0]           mwdata2, mrdata2;
  logic [7:0]            mbe2;

  tcdm_bank_arbiter #(.NumInp(2), .DataWidth(64), .MemAddrWidth(9)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v2), .req_write_i(w2), .req_addr_i(a2), .req_data_i(d2),
    .req_strb_i(s2), .req_ready_o(ready2), .rsp_valid_o(rspv2),
    .rsp_data_o(rspd2), .mem_req_o(mreq2), .mem_gnt_i(gnt2), .mem_we_o(mwe2),
    .mem_addr_o(maddr2), .mem_wdata_o(mwdata2), .mem_be_o(mbe2),
    .mem_rdata_i(mrdata2)
  );

  // ---------------- SRAM models ----------------
  logic [63:0] wr4 [int];
  logic [63:0] wr2 [int];

  function automatic logic [63:0] merge(input logic [63:0] old_w,
                                        input logic [63:0] new_w,
                                        input logic [7:0]  be);
    logic [63:0] r;
    r = old_w;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] word4(input logic [8:0] a);
    return wr4.exists(int'(a)) ? wr4[int'(a)] : 64'h1000 + 64'(a);
  endfunction

  function automatic logic [63:0] word2(input logic [8:0] a);
    return wr2.exists(int'(a)) ? wr2[int'(a)] : 64'h1000 + 64'(a);
  endfunction

  always @(posedge clk) begin
    if (mreq4 && gnt4) begin
      if (mwe4) wr4[int'(maddr4)] = merge(word4(maddr4), mwdata4, mbe4);
      else      mrdata4 <= word4(maddr4);
    end
  end

  always @(posedge clk) begin
    if (mreq2 && gnt2) begin
      if (mwe2) wr2[int'(maddr2)] = merge(word2(maddr2), mwdata2, mbe2);
      else      mrdata2 <= word2(maddr2);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int which);
    return (which == 4) ? sb4.size() : sb2.size();
  endfunction

  function automatic exp_t qfront(input int which);
    return (which == 4) ? sb4[0] : sb2[0];
  endfunction

  function automatic exp_t qpop(input int which);
    if (which == 4) return sb4.pop_front();
    return sb2.pop_front();
  endfunction

  task automatic mon(input int which, input logic [3:0] v,
                     input logic [3:0][63:0] d);
    exp_t        e;
    int          p;
    logic [63:0] others;
    string       tag;
    tag    = (which == 4) ? "dut4" : "dut2";
    others = '0;
    if (v == '0) begin
      check({tag, " idle rsp_data"}, d[0] | d[1] | d[2] | d[3], 64'h0);
      if (qsize(which) > 0 && qfront(which).due <= cyc) begin
        e = qpop(which);
        check({tag, " rsp missing"}, 64'(v), 64'(1) << e.port);
      end
    end else begin
      p = 0;
      for (int i = 3; i >= 0; i--) if (v[i]) p = i;
      check({tag, " rsp onehot"}, 64'($countones(v)), 64'd1);
      for (int i = 0; i < 4; i++) if (i != p) others = others | d[i];
      check({tag, " rsp_data other ports"}, others, 64'h0);
      if (qsize(which) == 0) begin
        check({tag, " unexpected rsp"}, 64'(v), 64'h0);
      end else begin
        e = qpop(which);
        check({tag, " rsp port"}, 64'(p), 64'(e.port));
        check({tag, " rsp data"}, d[p], e.data);
        check({tag, " rsp cycle"}, 64'(cyc), 64'(e.due));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(4, rspv4, rspd4);
    mon(2, {2'b00, rspv2}, {128'h0, rspd2});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input int p, input logic w, input logic [8:0] a,
                        input logic [63:0] d, input logic [7:0] s);
    v4[p] = 1'b1; w4[p] = w; a4[p] = a; d4[p] = d; s4[p] = s;
  endtask

  task automatic clear4(input int p);
    v4[p] = 1'b0; w4[p] = 1'b0; a4[p] = '0; d4[p] = '0; s4[p] = '0;
  endtask

  task automatic push4(input int p, input logic [63:0] data);
    sb4.push_back('{port: p, data: data, due: cyc + 1});
  endtask

  task automatic push2(input int p, input logic [63:0] data);
    sb2.push_back('{port: p, data: data, due: cyc + 1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected run to complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          win_seq [6] = '{0, 1, 0, 1, 0, 1};
    int          n0, n1;
    logic [8:0]  addr;

    v4 = '0; w4 = '0; a4 = '0; d4 = '0; s4 = '0; gnt4 = 1'b1;
    v2 = '0; w2 = '0; a2 = '0; d2 = '0; s2 = '0; gnt2 = 1'b1;

    // Reset state with nothing requested.
    tick(); tick();
    check("rst mem_req",   64'(mreq4),   64'h0);
    check("rst ready",     64'(ready4),  64'h0);
    check("rst rsp_valid", 64'(rspv4),   64'h0);
    check("rst mem_addr",  64'(maddr4),  64'h0);
    check("rst mem_we",    64'(mwe4),    64'h0);
    check("rst mem_wdata", mwdata4,      64'h0);
    check("rst mem_be",    64'(mbe4),    64'h0);

    // Combinational path stays live during reset.
    drive4(2, 1'b0, 9'd7, 64'h0, 8'h0);
    #1;
    check("rst comb mem_req",  64'(mreq4),  64'h1);
    check("rst comb ready",    64'(ready4), 64'h4);
    check("rst comb mem_addr", 64'(maddr4), 64'h7);
    tick();
    check("rst no rsp", 64'(rspv4), 64'h0);
    clear4(2);
    rst_n = 1'b1;

    // NumInp=2, both ports read every cycle: grants alternate 0,1,0,1...
    n0 = 0; n1 = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      v2 = 2'b11; w2 = 2'b00;
      a2[0] = 9'h060 + 9'(n0);
      a2[1] = 9'h070 + 9'(n1);
      #1;
      addr = (win_seq[k] == 0) ? 9'h060 + 9'(n0) : 9'h070 + 9'(n1);
      check("rr2 ready",    64'(ready2), 64'(1) << win_seq[k]);
      check("rr2 mem_addr", 64'(maddr2), 64'(addr));
      push2(win_seq[k], 64'h1000 + 64'(addr));
      if (win_seq[k] == 0) n0++; else n1++;
    end
    tick();
    v2 = '0; a2 = '0;

    // Port 1 writes 0xAAAA to addr 5, then port 0 reads it back.
    drive4(1, 1'b1, 9'd5, 64'hAAAA, 8'hFF);
    #1;
    check("wr ready",     64'(ready4),  64'h2);
    check("wr mem_we",    64'(mwe4),    64'h1);
    check("wr mem_addr",  64'(maddr4),  64'h5);
    check("wr mem_wdata", mwdata4,      64'hAAAA);
    check("wr mem_be",    64'(mbe4),    64'hFF);
    tick();
    clear4(1);
    drive4(0, 1'b0, 9'd5, 64'h0, 8'h0);
    #1;
    check("rd ready",          64'(ready4), 64'h1);
    check("rd mem_we",         64'(mwe4),   64'h0);
    check("no rsp after write", 64'(rspv4), 64'h0);
    push4(0, 64'hAAAA);
    tick();
    clear4(0);

    // Pointer is 1; port 1 read moves it to 2.
    drive4(1, 1'b0, 9'd1, 64'h0, 8'h0);
    #1;
    check("p1 ready", 64'(ready4), 64'h2);
    push4(1, 64'h1001);
    tick();

    // Ports 1 and 3 valid with ptr=2: port 3 first, then port 1.
    drive4(1, 1'b0, 9'd9, 64'h0, 8'h0);
    drive4(3, 1'b0, 9'd3, 64'h0, 8'h0);
    #1;
    check("ptr2 ready",    64'(ready4), 64'h8);
    check("ptr2 mem_addr", 64'(maddr4), 64'h3);
    push4(3, 64'h1003);
    tick();
    clear4(3);
    #1;
    check("wrap ready",    64'(ready4), 64'h2);
    check("wrap mem_addr", 64'(maddr4), 64'h9);
    push4(1, 64'h1009);
    tick();
    clear4(1);

    // ptr=2; ports 0 and 2 valid, no grant for 3 cycles.
    gnt4 = 1'b0;
    drive4(0, 1'b0, 9'h010, 64'h0, 8'h0);
    drive4(2, 1'b0, 9'h012, 64'h0, 8'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("nognt ready",    64'(ready4), 64'h0);
      check("nognt mem_req",  64'(mreq4),  64'h1);
      check("nognt mem_addr", 64'(maddr4), 64'h012);
      tick();
    end
    gnt4 = 1'b1;
    #1;
    check("gnt ready",    64'(ready4), 64'h4);
    check("gnt mem_addr", 64'(maddr4), 64'h012);
    push4(2, 64'h1012);
    tick();
    clear4(2);
    #1;
    check("gnt2 ready",    64'(ready4), 64'h1);
    check("gnt2 mem_addr", 64'(maddr4), 64'h010);
    push4(0, 64'h1010);
    tick();
    clear4(0);

    // ptr=1; partial-strobe write by port 2 then read back.
    drive4(2, 1'b1, 9'h030, 64'h1122334455667788, 8'hF0);
    #1;
    check("strb ready",  64'(ready4), 64'h4);
    check("strb mem_be", 64'(mbe4),   64'hF0);
    tick();
    clear4(2);
    drive4(2, 1'b0, 9'h030, 64'h0, 8'h0);
    #1;
    check("strb rd ready", 64'(ready4), 64'h4);
    push4(2, 64'h1122334400001030);
    tick();
    clear4(2);

    // Only port 0 valid for 10 cycles: granted every cycle.
    for (int k = 0; k < 10; k++) begin
      drive4(0, 1'b0, 9'h020 + 9'(k), 64'h0, 8'h0);
      #1;
      check("single ready", 64'(ready4), 64'h1);
      push4(0, 64'h1020 + 64'(k));
      tick();
    end
    clear4(0);

    // ptr=1; port 1 read accepted, then reset before its response is used.
    drive4(1, 1'b0, 9'h040, 64'h0, 8'h0);
    #1;
    check("pre-rst ready", 64'(ready4), 64'h2);
    tick();
    clear4(1);
    rst_n = 1'b0;
    #1;
    check("in-rst rsp_valid", 64'(rspv4), 64'h0);
    tick();
    check("in-rst rsp_valid 2", 64'(rspv4), 64'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("release rsp_valid", 64'(rspv4), 64'h0);
    tick();
    // Without a pointer reset port 2 would win here.
    drive4(0, 1'b0, 9'h050, 64'h0, 8'h0);
    drive4(2, 1'b0, 9'h052, 64'h0, 8'h0);
    #1;
    check("post-rst rsp_valid", 64'(rspv4), 64'h0);
    check("post-rst ready",     64'(ready4), 64'h1);
    push4(0, 64'h1050);
    tick();
    clear4(0);
    #1;
    check("post-rst ready 2", 64'(ready4), 64'h4);
    push4(2, 64'h1052);
    tick();
    clear4(2);

    repeat (3) tick();
    check("sb4 drained", 64'(sb4.size()), 64'h0);
    check("sb2 drained", 64'(sb2.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
